// File: rtl/alu_pkg.sv
// Shared ALU definitions for the 6502 core datapath.
// Holds the opcode enum used by both the ALU and the CPU control unit,
// plus the datapath width.
package control_signals;

   localparam int ALU_WIDTH = 8;

   // 3-bit opcode; every encoding is currently assigned.
   typedef enum logic [2:0] {
      ALU_ADD          = 3'd0,
      ALU_AND          = 3'd1,
      ALU_OR           = 3'd2,
      ALU_XOR          = 3'd3,
      ALU_SHIFT_LEFT   = 3'd4,
      ALU_SHIFT_RIGHT  = 3'd5,
      ALU_ROTATE_LEFT  = 3'd6,
      ALU_ROTATE_RIGHT = 3'd7
   } alu_op_t;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle.
// master : control unit side, drives operands/opcode, reads result and flags.
// slave  : ALU side, reads operands/opcode, drives result and flags.
//   carry_in     : adder carry / bit rotated in
//   input_a      : operand A (shift/rotate source)
//   input_b      : operand B
//   invert_b     : bitwise-invert B before use
//   operation    : opcode
//   alu_out      : registered result
//   carry_out, overflow_out, zero_out, negative_out : registered flag candidates
interface alu_if;
   import control_signals::*;

   logic                 carry_in;
   logic [ALU_WIDTH-1:0] input_a;
   logic [ALU_WIDTH-1:0] input_b;
   logic                 invert_b;
   alu_op_t              operation;
   logic [ALU_WIDTH-1:0] alu_out;
   logic                 carry_out;
   logic                 overflow_out;
   logic                 zero_out;
   logic                 negative_out;

   modport master (
      output carry_in, input_a, input_b, invert_b, operation,
      input  alu_out, carry_out, overflow_out, zero_out, negative_out
   );

   modport slave (
      input  carry_in, input_a, input_b, invert_b, operation,
      output alu_out, carry_out, overflow_out, zero_out, negative_out
   );

endinterface

// File: rtl/alu_adder.sv
// 8-bit combinational ripple-carry adder with carry-out and signed overflow.
//   a, b      : addends (b is already the effective, possibly inverted, operand)
//   carry_in  : carry into bit 0
//   sum       : low 8 bits of a + b + carry_in
//   carry_out : bit 8 of the sum
//   overflow  : two's-complement overflow of the signed addition
module alu_adder
   import control_signals::*;
(
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic [ALU_WIDTH-1:0] sum,
   output logic                 carry_out,
   output logic                 overflow
);

   logic [ALU_WIDTH:0] carry_chain;

   assign carry_chain[0] = carry_in;

   generate
      for (genvar gi = 0; gi < ALU_WIDTH; gi++) begin : g_bit
         assign sum[gi]           = a[gi] ^ b[gi] ^ carry_chain[gi];
         assign carry_chain[gi+1] = (a[gi] & b[gi]) | (carry_chain[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign carry_out = carry_chain[ALU_WIDTH];

   // Overflow when both operands share a sign that the result does not.
   assign overflow = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) &&
                     (sum[ALU_WIDTH-1] != a[ALU_WIDTH-1]);

endmodule

// File: rtl/alu.sv
// 8-bit ALU for the 6502 datapath. Combines operand A, optionally inverted
// operand B and carry_in according to the opcode, and registers the result
// and N/Z/C/V flag candidates with one cycle of latency. A new operation is
// accepted every cycle; there is no handshake.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high, clears result and all flags
//   bus   : operand/result bundle (slave side)
module alu
   import control_signals::*;
(
   input  logic  clk,
   input  logic  reset,
   alu_if.slave  bus
);

   logic [ALU_WIDTH-1:0] b_eff;
   logic [ALU_WIDTH-1:0] add_sum;
   logic                 add_carry;
   logic                 add_overflow;

   logic [ALU_WIDTH-1:0] result_next;
   logic                 carry_next;
   logic                 overflow_next;

   logic [ALU_WIDTH-1:0] result_reg;
   logic                 carry_reg;
   logic                 overflow_reg;
   logic                 zero_reg;
   logic                 negative_reg;

   // SBC is ADD with invert_b=1 and carry_in=1 (two's complement via ~B+1).
   assign b_eff = bus.invert_b ? ~bus.input_b : bus.input_b;

   alu_adder u_adder (
      .a         (bus.input_a),
      .b         (b_eff),
      .carry_in  (bus.carry_in),
      .sum       (add_sum),
      .carry_out (add_carry),
      .overflow  (add_overflow)
   );

   always_comb begin
      result_next   = '0;
      carry_next    = 1'b0;
      overflow_next = 1'b0;
      case (bus.operation)
         ALU_ADD: begin
            result_next   = add_sum;
            carry_next    = add_carry;
            overflow_next = add_overflow;
         end
         ALU_AND: result_next = bus.input_a & b_eff;
         ALU_OR:  result_next = bus.input_a | b_eff;
         ALU_XOR: result_next = bus.input_a ^ b_eff;
         ALU_SHIFT_LEFT: begin
            result_next = {bus.input_a[ALU_WIDTH-2:0], 1'b0};
            carry_next  = bus.input_a[ALU_WIDTH-1];
         end
         ALU_SHIFT_RIGHT: begin
            result_next = {1'b0, bus.input_a[ALU_WIDTH-1:1]};
            carry_next  = bus.input_a[0];
         end
         ALU_ROTATE_LEFT: begin
            result_next = {bus.input_a[ALU_WIDTH-2:0], bus.carry_in};
            carry_next  = bus.input_a[ALU_WIDTH-1];
         end
         ALU_ROTATE_RIGHT: begin
            result_next = {bus.carry_in, bus.input_a[ALU_WIDTH-1:1]};
            carry_next  = bus.input_a[0];
         end
         // Unassigned encodings (none today) yield r=0, so Z=1 below.
         default: begin
            result_next   = '0;
            carry_next    = 1'b0;
            overflow_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         negative_reg <= 1'b0;
      end else begin
         result_reg   <= result_next;
         carry_reg    <= carry_next;
         overflow_reg <= overflow_next;
         zero_reg     <= (result_next == '0);
         negative_reg <= result_next[ALU_WIDTH-1];
      end
   end

   assign bus.alu_out      = result_reg;
   assign bus.carry_out    = carry_reg;
   assign bus.overflow_out = overflow_reg;
   assign bus.zero_out     = zero_reg;
   assign bus.negative_out = negative_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed table, reset sequences and random
// vectors checked against an arithmetic reference model.
module tb_alu;
   import control_signals::*;

   logic clk = 1'b0;
   logic reset;

   alu_if bus ();

   alu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      alu_op_t    op;
      logic [7:0] a;
      logic [7:0] b;
      logic       inv;
      logic       cin;
      logic [7:0] exp_r;
      logic       exp_c;
      logic       exp_v;
   } vec_t;

   vec_t vecs[15];

   // Expected packing: {r[7:0], C, V, Z, N}
   function automatic logic [11:0] pack_exp(logic [7:0] r, logic c, logic v);
      return {r, c, v, (r == 8'h00), r[7]};
   endfunction

   // Reference model from the arithmetic definitions, using plain integers.
   function automatic logic [11:0] model(alu_op_t op, logic [7:0] a, logic [7:0] b,
                                         logic inv, logic cin);
      int ai, bi, ci, r, c, v, s, sa, sb;
      ai = int'(a);
      bi = inv ? 255 - int'(b) : int'(b);
      ci = int'(cin);
      r = 0; c = 0; v = 0;
      case (op)
         ALU_ADD: begin
            s  = ai + bi + ci;
            r  = s % 256;
            c  = (s >= 256) ? 1 : 0;
            sa = (ai >= 128) ? ai - 256 : ai;
            sb = (bi >= 128) ? bi - 256 : bi;
            s  = sa + sb + ci;
            v  = (s > 127 || s < -128) ? 1 : 0;
         end
         ALU_AND:          r = ai & bi;
         ALU_OR:           r = ai | bi;
         ALU_XOR:          r = ai ^ bi;
         ALU_SHIFT_LEFT:   begin r = (ai * 2) % 256;      c = ai / 128; end
         ALU_SHIFT_RIGHT:  begin r = ai / 2;              c = ai % 2;   end
         ALU_ROTATE_LEFT:  begin r = (ai * 2) % 256 + ci; c = ai / 128; end
         ALU_ROTATE_RIGHT: begin r = ai / 2 + 128 * ci;   c = ai % 2;   end
         default: ;
      endcase
      return pack_exp(r[7:0], c[0], v[0]);
   endfunction

   task automatic drive(alu_op_t op, logic [7:0] a, logic [7:0] b, logic inv, logic cin);
      bus.operation = op;
      bus.input_a   = a;
      bus.input_b   = b;
      bus.invert_b  = inv;
      bus.carry_in  = cin;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [11:0] exp);
      logic [11:0] got;
      got = {bus.alu_out, bus.carry_out, bus.overflow_out, bus.zero_out, bus.negative_out};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got r=%h cvzn=%b required r=%h cvzn=%b",
                  name, got[11:4], got[3:0], exp[11:4], exp[3:0]);
      end else begin
         $display("ok   %s: r=%h cvzn=%b", name, got[11:4], got[3:0]);
      end
   endtask

   initial begin
      vecs[0]  = '{ALU_ADD,          8'h06, 8'h05, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0};
      vecs[1]  = '{ALU_SHIFT_LEFT,   8'hC3, 8'h01, 1'b0, 1'b0, 8'h86, 1'b1, 1'b0};
      vecs[2]  = '{ALU_ADD,          8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3]  = '{ALU_ADD,          8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[4]  = '{ALU_ADD,          8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[5]  = '{ALU_ADD,          8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[6]  = '{ALU_ROTATE_RIGHT, 8'h01, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
      vecs[7]  = '{ALU_AND,          8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[8]  = '{ALU_XOR,          8'hFF, 8'h0F, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0};
      vecs[9]  = '{ALU_OR,           8'h12, 8'h40, 1'b1, 1'b1, 8'hBF, 1'b0, 1'b0};
      vecs[10] = '{ALU_SHIFT_RIGHT,  8'h81, 8'hFF, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0};
      vecs[11] = '{ALU_ROTATE_LEFT,  8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[12] = '{ALU_ROTATE_LEFT,  8'h55, 8'h00, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0};
      vecs[13] = '{ALU_SHIFT_LEFT,   8'h40, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      vecs[14] = '{ALU_ADD,          8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

      // Reset state, with a nonzero ADD presented during reset.
      reset = 1'b1;
      drive(ALU_ADD, 8'h06, 8'h05, 1'b0, 1'b1);
      step();
      check("reset_state", 12'h000);
      reset = 1'b0;

      // Directed table, one operation per cycle.
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inv, vecs[i].cin);
         step();
         check($sformatf("vec%0d_%s", i, vecs[i].op.name()),
               pack_exp(vecs[i].exp_r, vecs[i].exp_c, vecs[i].exp_v));
      end

      // Reset mid-stream clears a nonzero result; the following edge loads normally.
      drive(ALU_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
      step();
      check("pre_reset_add", pack_exp(8'h80, 1'b0, 1'b1));
      reset = 1'b1;
      drive(ALU_ADD, 8'h06, 8'h05, 1'b0, 1'b1);
      step();
      check("reset_dominates_add", 12'h000);
      reset = 1'b0;
      step();
      check("post_reset_add", pack_exp(8'h0C, 1'b0, 1'b0));

      // Output holds while inputs change mid-cycle, until the next edge.
      drive(ALU_XOR, 8'hAA, 8'h55, 1'b0, 1'b0);
      #3;
      check("hold_until_edge", pack_exp(8'h0C, 1'b0, 1'b0));
      step();
      check("xor_after_hold", pack_exp(8'hFF, 1'b0, 1'b0));

      // Random back-to-back operations against the reference model.
      for (int i = 0; i < 300; i++) begin
         alu_op_t    op;
         logic [7:0] a, b;
         logic       inv, cin;
         op  = alu_op_t'($urandom_range(0, 7));
         a   = 8'($urandom_range(0, 255));
         b   = 8'($urandom_range(0, 255));
         inv = 1'($urandom_range(0, 1));
         cin = 1'($urandom_range(0, 1));
         drive(op, a, b, inv, cin);
         step();
         check($sformatf("rand%0d_%s a=%h b=%h i=%b c=%b", i, op.name(), a, b, inv, cin),
               model(op, a, b, inv, cin));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
